// File: rtl/sd_read_block.sv
// SPI-mode single-block read: CMD17, R1, start token, 512 data bytes, CRC drop.
// Card-facing pins launch on the falling edge; MISO is sampled on the rising edge.
module sd_read_block (
    input  logic        rst_n,
    input  logic        SD_clk,
    input  logic        init_i,
    input  logic        type_card,
    input  logic        start,
    input  logic [31:0] sector,
    output logic        SD_cs,
    output logic        SD_datain,
    input  logic        SD_dataout,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [8:0]  rd_index,
    output logic        done,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_R1, R1_RX, WAIT_TOK, DATA, CRC, FINISH
    } state_e;

    state_e      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  rx_q, rx_d;
    logic [47:0] cmd_q, cmd_d;
    logic        mosi_q, mosi_d;
    logic        csn_q, csn_d;
    logic        busy_q, busy_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic [8:0]  rd_index_q, rd_index_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic        cs_q, datain_q;

    logic [31:0] arg;
    logic [7:0]  byte_val;
    logic        byte_end;
    logic        abort;

    assign arg      = type_card ? sector : {sector[22:0], 9'b0};
    assign byte_val = {rx_q, SD_dataout};
    assign byte_end = (bit_q == 3'd7);
    assign abort    = !init_i && (state_q != IDLE) && (state_q != FINISH);

    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start && init_i) state_d = SEND;
            SEND:     if (cnt_q == 13'd46) state_d = WAIT_R1;
            WAIT_R1: begin
                if (!SD_dataout)                 state_d = R1_RX;
                else if (cnt_q[8:0] == 9'd511)   state_d = FINISH;
            end
            R1_RX: begin
                if (byte_end) state_d = (byte_val == 8'h00) ? WAIT_TOK : FINISH;
            end
            WAIT_TOK: begin
                if (byte_end) begin
                    if (byte_val == 8'hFE)            state_d = DATA;
                    else if (byte_val[7:4] == 4'h0)   state_d = FINISH;
                    else if (cnt_q == 13'd8191)       state_d = FINISH;
                end
            end
            DATA:     if (byte_end && cnt_q[8:0] == 9'd511) state_d = CRC;
            CRC:      if (cnt_q[3:0] == 4'd15) state_d = FINISH;
            FINISH:   if (cnt_q[2:0] == 3'd7) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort) state_d = FINISH;
    end

    always_comb begin
        cnt_d      = cnt_q;
        bit_d      = 3'd0;
        rx_d       = {rx_q[5:0], SD_dataout};
        cmd_d      = cmd_q;
        mosi_d     = 1'b1;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_index_d = rd_index_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (state_d == SEND) begin
                    cmd_d  = {8'h51, arg, 8'hFF};
                    mosi_d = cmd_d[47];
                    err_d  = 2'd0;
                end
            end
            SEND: begin
                cmd_d = cmd_q << 1;
                if (!abort) mosi_d = cmd_q[46];
                cnt_d = cnt_q + 13'd1;
            end
            WAIT_R1: begin
                // the 0 bit that ends the search is R1 bit 7
                bit_d = 3'd1;
                cnt_d = cnt_q + 13'd1;
            end
            R1_RX: bit_d = bit_q + 3'd1;
            WAIT_TOK: begin
                bit_d = bit_q + 3'd1;
                if (byte_end) cnt_d = cnt_q + 13'd1;
            end
            DATA: begin
                bit_d = bit_q + 3'd1;
                if (byte_end) begin
                    cnt_d      = cnt_q + 13'd1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = byte_val;
                    rd_index_d = cnt_q[8:0];
                end
            end
            CRC:     cnt_d = cnt_q + 13'd1;
            FINISH:  cnt_d = cnt_q + 13'd1;
            default: cnt_d = cnt_q;
        endcase
        if (state_d != state_q) cnt_d = 13'd0;
        if (state_d == FINISH && state_q != FINISH) begin
            if (abort)                    err_d = 2'd2;
            else if (state_q == R1_RX)    err_d = 2'd1;
            else if (state_q == WAIT_TOK) err_d = 2'd3;
            else if (state_q == WAIT_R1)  err_d = 2'd2;
        end
    end

    assign csn_d  = (state_d == IDLE) || (state_d == FINISH);
    assign busy_d = (state_d != IDLE);
    assign done_d = (state_q == FINISH) && (state_d == IDLE);

    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 13'd0;
            bit_q      <= 3'd0;
            rx_q       <= 7'd0;
            cmd_q      <= 48'd0;
            mosi_q     <= 1'b1;
            csn_q      <= 1'b1;
            busy_q     <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            rd_index_q <= 9'd0;
            done_q     <= 1'b0;
            err_q      <= 2'd0;
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            rx_q       <= rx_d;
            cmd_q      <= cmd_d;
            mosi_q     <= mosi_d;
            csn_q      <= csn_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_index_q <= rd_index_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // card pins move half a clock after the decision that set them
    always_ff @(negedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q     <= 1'b1;
            datain_q <= 1'b1;
        end else begin
            cs_q     <= csn_q;
            datain_q <= mosi_q;
        end
    end

    assign SD_cs     = cs_q;
    assign SD_datain = datain_q;
    assign busy      = busy_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_index  = rd_index_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sd_read_block.sv
// Bench for sd_read_block: a bit-queue SD card model and a
// cycle-arithmetic reference for command, status, data and timing.
module tb_sd_read_block;

    logic        SD_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_i = 1'b0;
    logic        type_card = 1'b0;
    logic        start = 1'b0;
    logic [31:0] sector = 32'd0;
    logic        SD_dataout = 1'b1;
    logic        SD_cs, SD_datain, busy, rd_valid, done;
    logic [7:0]  rd_data;
    logic [8:0]  rd_index;
    logic [1:0]  err;

    sd_read_block dut (
        .rst_n(rst_n), .SD_clk(SD_clk), .init_i(init_i),
        .type_card(type_card), .start(start), .sector(sector),
        .SD_cs(SD_cs), .SD_datain(SD_datain), .SD_dataout(SD_dataout),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_index(rd_index), .done(done), .err(err)
    );

    initial forever #5 SD_clk = ~SD_clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int idx;
        int dat;
        int cyc;
    } strobe_t;

    bit      resp_q[$];
    bit      mosi_bits[$];
    strobe_t strobes[$];
    int      cs_low_cnt = 0;
    int      cs_high_run = 0;
    int      ncyc = 0;
    bit      done_seen = 0;
    int      done_ncyc, done_err, done_cshigh, done_busy;
    event    mon_ev;

    logic [47:0] exp_cmd;
    int          exp_err, exp_fin, exp_n, exp_first;
    logic [7:0]  exp_data [512];
    int          s_cyc;

    initial forever begin
        @(posedge SD_clk);
        if (SD_cs === 1'b0) begin
            cs_high_run = 0;
            cs_low_cnt++;
            if (mosi_bits.size() < 48) mosi_bits.push_back(SD_datain);
        end else begin
            cs_high_run++;
        end
    end

    // monitor, then card: response bits begin once 47 command bits are in
    initial forever begin
        strobe_t s;
        @(negedge SD_clk);
        ncyc++;
        if (rd_valid === 1'b1) begin
            s.idx = int'(rd_index);
            s.dat = int'(rd_data);
            s.cyc = ncyc;
            strobes.push_back(s);
        end
        if (done === 1'b1) begin
            done_seen   = 1;
            done_ncyc   = ncyc;
            done_err    = int'(err);
            done_busy   = int'(busy);
            done_cshigh = cs_high_run;
        end
        if (cs_low_cnt >= 47 && resp_q.size() > 0) SD_dataout = resp_q.pop_front();
        else                                       SD_dataout = 1'b1;
        -> mon_ev;
    end

    task automatic push_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) resp_q.push_back(v[b]);
    endtask

    task automatic prep(input bit hc, input logic [31:0] sec, input int d,
                        input logic [7:0] r1, input int g, input logic [7:0] tok,
                        input bit silent, input bit idx_data);
        logic [31:0] arg;
        arg     = hc ? sec : sec * 32'd512;
        exp_cmd = {8'h51, arg, 8'hFF};
        resp_q.delete();
        mosi_bits.delete();
        strobes.delete();
        cs_low_cnt = 0;
        done_seen  = 0;
        exp_n      = 0;
        exp_first  = 0;
        if (silent) begin
            exp_err = 2;
            exp_fin = 559;
        end else begin
            for (int i = 0; i < d; i++) resp_q.push_back(1'b1);
            push_byte(r1);
            if (r1 != 8'h00) begin
                exp_err = 1;
                exp_fin = 55 + d;
            end else begin
                for (int i = 0; i < 8 * g; i++) resp_q.push_back(1'b1);
                push_byte(tok);
                if (tok == 8'hFE) begin
                    for (int i = 0; i < 512; i++) begin
                        exp_data[i] = idx_data ? 8'(i) : 8'($urandom);
                        push_byte(exp_data[i]);
                    end
                    push_byte(8'($urandom));
                    push_byte(8'($urandom));
                    exp_err   = 0;
                    exp_fin   = 4175 + d + 8 * g;
                    exp_n     = 512;
                    exp_first = 71 + d + 8 * g;
                end else begin
                    exp_err = 3;
                    exp_fin = 63 + d + 8 * g;
                end
            end
        end
        type_card = hc;
        sector    = sec;
    endtask

    task automatic launch(input bit now);
        if (!now) @(mon_ev);
        start = 1'b1;
        s_cyc = ncyc;
        @(mon_ev);
        start = 1'b0;
    endtask

    task automatic wait_txn(input int poke_at, input bit full);
        logic [47:0] w;
        int nm;
        for (int i = 0; i < 6000 && !done_seen; i++) begin
            @(mon_ev);
            if (i == poke_at) begin
                chk("busy_mid", busy, 1);
                start = 1'b1;
            end else if (i == poke_at + 1) begin
                start = 1'b0;
            end
        end
        chk("done_seen", done_seen, 1);
        chk("err", done_err, exp_err);
        chk("busy_at_done", done_busy, 0);
        chk("cs_high_before_done", done_cshigh, 8);
        w = '0;
        foreach (mosi_bits[i]) w = {w[46:0], mosi_bits[i]};
        chk("cmd", w, exp_cmd);
        if (full) begin
            chk("latency", done_ncyc - s_cyc - 1, exp_fin + 8);
            chk("cs_low_clocks", cs_low_cnt, exp_fin);
            chk("nstrobe", strobes.size(), exp_n);
            nm = 0;
            foreach (strobes[i]) begin
                if (i < 512 && strobes[i].idx == i &&
                    strobes[i].dat == int'(exp_data[i]) &&
                    strobes[i].cyc - s_cyc - 1 == exp_first + 8 * i) nm++;
            end
            chk("data", nm, exp_n);
        end
    endtask

    task automatic rd(input bit hc, input logic [31:0] sec, input int d,
                      input logic [7:0] r1, input int g, input logic [7:0] tok,
                      input bit silent, input bit idx_data);
        prep(hc, sec, d, r1, g, tok, silent, idx_data);
        launch(0);
        wait_txn(-10, 1);
    endtask

    initial begin
        repeat (3) @(mon_ev);
        #1;
        chk("rst_cs", SD_cs, 1);
        chk("rst_mosi", SD_datain, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_index", rd_index, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(mon_ev);
        rst_n  = 1'b1;
        init_i = 1'b1;
        repeat (2) @(mon_ev);

        rd(1, 32'h0000_1234, 16, 8'h00, 10, 8'hFE, 0, 1);
        rd(0, 32'h0000_0003, 16, 8'h00, 10, 8'hFE, 0, 1);
        rd(1, $urandom, 5, 8'h04, 0, 8'h00, 0, 0);
        rd(1, $urandom, 0, 8'h00, 0, 8'h00, 1, 0);
        rd(0, $urandom, 3, 8'h00, 2, 8'h08, 0, 0);

        // start pulsed mid-transfer must not restart the read
        prep(1, $urandom, 7, 8'h00, 1, 8'hFE, 0, 0);
        launch(0);
        wait_txn(1000, 1);
        repeat (10) @(mon_ev);
        chk("no_restart_cs", cs_low_cnt, exp_fin);
        chk("no_restart_busy", busy, 0);

        // start without init is ignored
        init_i = 1'b0;
        prep(1, 32'h55, 0, 8'h00, 0, 8'hFE, 0, 1);
        resp_q.delete();
        launch(0);
        repeat (20) @(mon_ev);
        chk("init0_busy", busy, 0);
        chk("init0_cs", cs_low_cnt, 0);
        init_i = 1'b1;
        repeat (2) @(mon_ev);

        // start held in the done cycle chains a new command
        prep(0, $urandom, 1, 8'h00, 0, 8'hFE, 0, 0);
        launch(0);
        wait_txn(-10, 1);
        prep(1, $urandom, 12, 8'h00, 3, 8'hFE, 0, 0);
        launch(1);
        wait_txn(-10, 1);

        // init dropping mid-data aborts with status 2
        prep(1, $urandom, 4, 8'h00, 1, 8'hFE, 0, 0);
        launch(0);
        for (int i = 0; i < 3000 && strobes.size() < 50; i++) @(mon_ev);
        init_i  = 1'b0;
        exp_err = 2;
        wait_txn(-10, 0);
        init_i = 1'b1;
        resp_q.delete();
        repeat (4) @(mon_ev);

        // asynchronous reset at data byte 200
        prep(1, $urandom, 2, 8'h00, 1, 8'hFE, 0, 1);
        launch(0);
        for (int i = 0; i < 5000 && strobes.size() < 201; i++) @(mon_ev);
        chk("rst_reached", strobes.size(), 201);
        rst_n = 1'b0;
        #1;
        chk("arst_cs", SD_cs, 1);
        chk("arst_busy", busy, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_rd_index", rd_index, 0);
        resp_q.delete();
        repeat (3) @(mon_ev);
        rst_n = 1'b1;
        repeat (10) @(mon_ev);
        chk("arst_no_done", done_seen, 0);
        rd(1, 32'h0000_1234, 16, 8'h00, 10, 8'hFE, 0, 1);

        for (int k = 0; k < 2; k++) begin
            rd(1'($urandom), $urandom, int'($urandom_range(40, 0)), 8'h00,
               int'($urandom_range(12, 0)), 8'hFE, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
